// File: rtl/axi_wdata_router_if.sv
// Bundled AW-capture and W-routing signals between the AW arbiter, three W masters and three W slaves.
// Modport slave is the router's view; modport master is the surrounding fabric's view.
interface axi_wdata_router_if #(
  parameter int DATA_W = 32,
  parameter int STRB_W = 4,
  parameter int LEN_W  = 4,
  parameter int ADDR_W = 32
);
  logic              AW_VALID;
  logic              AW_READY;
  logic [1:0]        AW_MASTER;
  logic [ADDR_W-1:0] AW_ADDR;
  logic [LEN_W-1:0]  AW_LEN;
  logic              AW_FREE;

  logic [DATA_W-1:0] WDATA_M0, WDATA_M1, WDATA_M2;
  logic [STRB_W-1:0] WSTRB_M0, WSTRB_M1, WSTRB_M2;
  logic              WLAST_M0, WLAST_M1, WLAST_M2;
  logic              WVALID_M0, WVALID_M1, WVALID_M2;
  logic              WREADY_M0, WREADY_M1, WREADY_M2;

  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WLAST;
  logic              WVALID_S0, WVALID_S1, WVALID_S2;
  logic              WREADY_S0, WREADY_S1, WREADY_S2;

  logic              W_LAST_ERR;

  modport slave (
    input  AW_VALID, AW_READY, AW_MASTER, AW_ADDR, AW_LEN,
    input  WDATA_M0, WDATA_M1, WDATA_M2,
    input  WSTRB_M0, WSTRB_M1, WSTRB_M2,
    input  WLAST_M0, WLAST_M1, WLAST_M2,
    input  WVALID_M0, WVALID_M1, WVALID_M2,
    input  WREADY_S0, WREADY_S1, WREADY_S2,
    output AW_FREE,
    output WREADY_M0, WREADY_M1, WREADY_M2,
    output WDATA, WSTRB, WLAST,
    output WVALID_S0, WVALID_S1, WVALID_S2,
    output W_LAST_ERR
  );

  modport master (
    output AW_VALID, AW_READY, AW_MASTER, AW_ADDR, AW_LEN,
    output WDATA_M0, WDATA_M1, WDATA_M2,
    output WSTRB_M0, WSTRB_M1, WSTRB_M2,
    output WLAST_M0, WLAST_M1, WLAST_M2,
    output WVALID_M0, WVALID_M1, WVALID_M2,
    output WREADY_S0, WREADY_S1, WREADY_S2,
    input  AW_FREE,
    input  WREADY_M0, WREADY_M1, WREADY_M2,
    input  WDATA, WSTRB, WLAST,
    input  WVALID_S0, WVALID_S1, WVALID_S2,
    input  W_LAST_ERR
  );
endinterface

// File: rtl/axi_wdata_router.sv
// W-channel router: latches one granted AW burst, routes its beats master->slave, generates WLAST.
// Optional WDATA_LAST_CHECK_EN adds a sticky flag for master WLAST disagreeing with the router count.
module axi_wdata_router #(
  parameter int DATA_W = 32,
  parameter int STRB_W = 4,
  parameter int LEN_W  = 4,
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  axi_wdata_router_if.slave  bus
);

  typedef enum logic {IDLE, BURST} state_t;
  typedef enum logic [1:0] {SEL_S0, SEL_S1, SEL_S2, SEL_DEF} slave_t;

  state_t           state, state_next;
  slave_t           sel_s, sel_s_next;
  logic [1:0]       sel_m, sel_m_next;
  logic [LEN_W-1:0] cnt, cnt_next;

  logic [DATA_W-1:0] m_data;
  logic [STRB_W-1:0] m_strb;
  logic              m_valid;
  logic              m_last;
  logic              s_ready;
  logic              last_now;
  logic              beat;

  function automatic slave_t decode_slave(input logic [15:0] region);
    case (region)
      16'h0000: decode_slave = SEL_S0;
      16'h0001: decode_slave = SEL_S1;
      16'h0002: decode_slave = SEL_S2;
      default:  decode_slave = SEL_DEF;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sel_m <= 2'd3;
      sel_s <= SEL_DEF;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      sel_m <= sel_m_next;
      sel_s <= sel_s_next;
    end
  end

  // Selected-master payload and selected-slave ready; the DEFAULT sink always accepts.
  always_comb begin
    m_data  = '0;
    m_strb  = '0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    case (sel_m)
      2'd0: begin
        m_data  = bus.WDATA_M0;
        m_strb  = bus.WSTRB_M0;
        m_valid = bus.WVALID_M0;
        m_last  = bus.WLAST_M0;
      end
      2'd1: begin
        m_data  = bus.WDATA_M1;
        m_strb  = bus.WSTRB_M1;
        m_valid = bus.WVALID_M1;
        m_last  = bus.WLAST_M1;
      end
      2'd2: begin
        m_data  = bus.WDATA_M2;
        m_strb  = bus.WSTRB_M2;
        m_valid = bus.WVALID_M2;
        m_last  = bus.WLAST_M2;
      end
      default: ;
    endcase

    s_ready = 1'b1;
    case (sel_s)
      SEL_S0:  s_ready = bus.WREADY_S0;
      SEL_S1:  s_ready = bus.WREADY_S1;
      SEL_S2:  s_ready = bus.WREADY_S2;
      default: s_ready = 1'b1;
    endcase
  end

  assign last_now = (cnt == '0);

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    sel_m_next    = sel_m;
    sel_s_next    = sel_s;
    beat          = 1'b0;
    bus.AW_FREE   = 1'b0;
    bus.WDATA     = '0;
    bus.WSTRB     = '0;
    bus.WLAST     = 1'b0;
    bus.WREADY_M0 = 1'b0;
    bus.WREADY_M1 = 1'b0;
    bus.WREADY_M2 = 1'b0;
    bus.WVALID_S0 = 1'b0;
    bus.WVALID_S1 = 1'b0;
    bus.WVALID_S2 = 1'b0;

    case (state)
      IDLE: begin
        bus.AW_FREE = 1'b1;
        // A handshake carrying the "no master" code is not a real grant.
        if (bus.AW_VALID && bus.AW_READY && (bus.AW_MASTER != 2'd3)) begin
          sel_m_next = bus.AW_MASTER;
          sel_s_next = decode_slave(bus.AW_ADDR[31:16]);
          cnt_next   = bus.AW_LEN;
          state_next = BURST;
        end
      end
      BURST: begin
        bus.WDATA = m_data;
        bus.WSTRB = m_strb;
        bus.WLAST = last_now;
        case (sel_s)
          SEL_S0:  bus.WVALID_S0 = m_valid;
          SEL_S1:  bus.WVALID_S1 = m_valid;
          SEL_S2:  bus.WVALID_S2 = m_valid;
          default: ;
        endcase
        case (sel_m)
          2'd0:    bus.WREADY_M0 = s_ready;
          2'd1:    bus.WREADY_M1 = s_ready;
          2'd2:    bus.WREADY_M2 = s_ready;
          default: ;
        endcase
        beat = m_valid && s_ready;
        if (beat) begin
          if (last_now) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt - 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef WDATA_LAST_CHECK_EN
  logic w_last_err, w_last_err_next;
  logic unused_bits;

  // The burst still ends on the router count; the flag only records the disagreement.
  always_comb begin
    w_last_err_next = w_last_err;
    if (beat && (m_last != last_now)) begin
      w_last_err_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_last_err <= 1'b0;
    end else begin
      w_last_err <= w_last_err_next;
    end
  end

  assign bus.W_LAST_ERR = w_last_err;
  assign unused_bits    = ^bus.AW_ADDR[15:0];
`else
  logic unused_bits;

  assign bus.W_LAST_ERR = 1'b0;
  assign unused_bits    = ^{bus.AW_ADDR[15:0], m_last};
`endif

endmodule

// File: tb/tb_axi_wdata_router.sv
// Directed bench for axi_wdata_router: stimulus pushes expected beats, a negedge monitor pops and compares.
// Runs in both builds; W_LAST_ERR expectations follow WDATA_LAST_CHECK_EN.
module tb_axi_wdata_router;

  typedef struct packed {
    logic [1:0]  m;
    logic [2:0]  s;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } beat_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  beat_t exp_q[$];

  axi_wdata_router_if #(.DATA_W(32), .STRB_W(4), .LEN_W(4), .ADDR_W(32)) bus ();

  axi_wdata_router #(.DATA_W(32), .STRB_W(4), .LEN_W(4), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef WDATA_LAST_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int m, input logic valid, input logic [31:0] data,
                               input logic [3:0] strb, input logic last);
    case (m)
      0: begin bus.WVALID_M0 = valid; bus.WDATA_M0 = data; bus.WSTRB_M0 = strb; bus.WLAST_M0 = last; end
      1: begin bus.WVALID_M1 = valid; bus.WDATA_M1 = data; bus.WSTRB_M1 = strb; bus.WLAST_M1 = last; end
      default: begin bus.WVALID_M2 = valid; bus.WDATA_M2 = data; bus.WSTRB_M2 = strb; bus.WLAST_M2 = last; end
    endcase
  endtask

  // Drives one AW handshake in the current cycle; the router is in BURST on return.
  task automatic issueAw(input logic [1:0] m, input logic [31:0] addr, input logic [3:0] len);
    bus.AW_VALID  = 1'b1;
    bus.AW_READY  = 1'b1;
    bus.AW_MASTER = m;
    bus.AW_ADDR   = addr;
    bus.AW_LEN    = len;
    #1;
    checkOutput("aw_free_before_aw", 32'(bus.AW_FREE), 32'd1);
    step();
    bus.AW_VALID = 1'b0;
    bus.AW_READY = 1'b0;
    #1;
    checkOutput("aw_free_in_burst", 32'(bus.AW_FREE), 32'd0);
  endtask

  task automatic pushBeat(input logic [1:0] m, input logic [2:0] s, input logic [31:0] data,
                          input logic [3:0] strb, input logic last);
    beat_t b;
    b.m = m; b.s = s; b.data = data; b.strb = strb; b.last = last;
    exp_q.push_back(b);
  endtask

  // Monitor: every accepted master beat must match the oldest expected entry.
  always @(negedge clk) begin
    logic [2:0] mv, mr;
    beat_t got, want;
    mv = {bus.WVALID_M2, bus.WVALID_M1, bus.WVALID_M0};
    mr = {bus.WREADY_M2, bus.WREADY_M1, bus.WREADY_M0};
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (mv[i] && mr[i]) begin
          got.m    = 2'(i);
          got.s    = {bus.WVALID_S2, bus.WVALID_S1, bus.WVALID_S0};
          got.data = bus.WDATA;
          got.strb = bus.WSTRB;
          got.last = bus.WLAST;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL beat_unexpected: got %h want none", got);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              bad++;
              $display("[TB] FAIL beat: got %h want %h", got, want);
            end
          end
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.AW_VALID = 1'b0; bus.AW_READY = 1'b0; bus.AW_MASTER = 2'd3;
    bus.AW_ADDR  = '0;   bus.AW_LEN   = '0;
    for (int m = 0; m < 3; m++) applyStimulus(m, 1'b0, 32'h0, 4'h0, 1'b0);
    bus.WREADY_S0 = 1'b0; bus.WREADY_S1 = 1'b0; bus.WREADY_S2 = 1'b0;

    // T1: reset
    step();
    step();
    checkOutput("rst_aw_free", 32'(bus.AW_FREE), 32'd1);
    checkOutput("rst_wvalid_s", 32'({bus.WVALID_S2, bus.WVALID_S1, bus.WVALID_S0}), 32'd0);
    checkOutput("rst_wready_m", 32'({bus.WREADY_M2, bus.WREADY_M1, bus.WREADY_M0}), 32'd0);
    checkOutput("rst_wlast", 32'(bus.WLAST), 32'd0);
    checkOutput("rst_last_err", 32'(bus.W_LAST_ERR), 32'd0);
    rst = 1'b0;

    // AW with the "no master" code is ignored; W from a master is ignored in IDLE.
    bus.AW_VALID = 1'b1; bus.AW_READY = 1'b1; bus.AW_MASTER = 2'd3; bus.AW_ADDR = 32'h0001_0000;
    applyStimulus(0, 1'b1, 32'hDEAD_0000, 4'hF, 1'b1);
    step();
    bus.AW_VALID = 1'b0; bus.AW_READY = 1'b0;
    #1;
    checkOutput("m3_ignored_free", 32'(bus.AW_FREE), 32'd1);
    checkOutput("idle_wready_m0", 32'(bus.WREADY_M0), 32'd0);
    step();

    // T2: M1 -> S1, 4 beats, M0 also asserting WVALID but unselected
    bus.WREADY_S0 = 1'b1; bus.WREADY_S1 = 1'b1; bus.WREADY_S2 = 1'b1;
    issueAw(2'd1, 32'h0001_0000, 4'd3);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 1'b1, 32'hA000_0000 + 32'(k), 4'hF, k == 3);
      pushBeat(2'd1, 3'b010, 32'hA000_0000 + 32'(k), 4'hF, k == 3);
      #1;
      checkOutput("t2_wlast", 32'(bus.WLAST), 32'(k == 3));
      checkOutput("t2_unsel_wready_m0", 32'(bus.WREADY_M0), 32'd0);
      step();
    end
    applyStimulus(1, 1'b0, 32'h0, 4'h0, 1'b0);
    applyStimulus(0, 1'b0, 32'h0, 4'h0, 1'b0);
    #1;
    checkOutput("t2_free_after", 32'(bus.AW_FREE), 32'd1);

    // T3: M0 -> S0, single beat held off by slave for three cycles
    bus.WREADY_S0 = 1'b0;
    issueAw(2'd0, 32'h0000_0040, 4'd0);
    applyStimulus(0, 1'b1, 32'h1234_5678, 4'h3, 1'b1);
    pushBeat(2'd0, 3'b001, 32'h1234_5678, 4'h3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("t3_wvalid_s0_held", 32'(bus.WVALID_S0), 32'd1);
      checkOutput("t3_wlast_held", 32'(bus.WLAST), 32'd1);
      checkOutput("t3_free_held", 32'(bus.AW_FREE), 32'd0);
      step();
    end
    bus.WREADY_S0 = 1'b1;
    step();
    applyStimulus(0, 1'b0, 32'h0, 4'h0, 1'b0);
    #1;
    checkOutput("t3_free_after", 32'(bus.AW_FREE), 32'd1);

    // T4: M2 -> DEFAULT sink with every slave refusing
    bus.WREADY_S0 = 1'b0; bus.WREADY_S1 = 1'b0; bus.WREADY_S2 = 1'b0;
    issueAw(2'd2, 32'h0005_0000, 4'd1);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(2, 1'b1, 32'hC0DE_0000 + 32'(k), 4'h8, 1'b0);
      pushBeat(2'd2, 3'b000, 32'hC0DE_0000 + 32'(k), 4'h8, k == 1);
      #1;
      checkOutput("t4_wready_m2", 32'(bus.WREADY_M2), 32'd1);
      step();
    end
    applyStimulus(2, 1'b0, 32'h0, 4'h0, 1'b0);
    #1;
    checkOutput("t4_free_after", 32'(bus.AW_FREE), 32'd1);

    // T5: reset after 2 of 8 beats, then a fresh 2-beat burst
    bus.WREADY_S0 = 1'b1; bus.WREADY_S1 = 1'b1; bus.WREADY_S2 = 1'b1;
    issueAw(2'd1, 32'h0002_0000, 4'd7);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 1'b1, 32'h5500_0000 + 32'(k), 4'hF, 1'b0);
      pushBeat(2'd1, 3'b100, 32'h5500_0000 + 32'(k), 4'hF, 1'b0);
      step();
    end
    applyStimulus(1, 1'b0, 32'h0, 4'h0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checkOutput("t5_free_after_rst", 32'(bus.AW_FREE), 32'd1);
    checkOutput("t5_wvalid_s_after_rst", 32'({bus.WVALID_S2, bus.WVALID_S1, bus.WVALID_S0}), 32'd0);
    issueAw(2'd0, 32'h0000_0100, 4'd1);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 1'b1, 32'h6600_0000 + 32'(k), 4'h1, k == 1);
      pushBeat(2'd0, 3'b001, 32'h6600_0000 + 32'(k), 4'h1, k == 1);
      step();
    end
    applyStimulus(0, 1'b0, 32'h0, 4'h0, 1'b0);
    #1;
    checkOutput("t5_free_after", 32'(bus.AW_FREE), 32'd1);

    // T6: master claims WLAST one beat early
    issueAw(2'd0, 32'h0000_0000, 4'd2);
    applyStimulus(0, 1'b1, 32'h7700_0000, 4'hF, 1'b0);
    pushBeat(2'd0, 3'b001, 32'h7700_0000, 4'hF, 1'b0);
    step();
    checkOutput("t6_err_after_beat1", 32'(bus.W_LAST_ERR), 32'd0);
    applyStimulus(0, 1'b1, 32'h7700_0001, 4'hF, 1'b1);
    pushBeat(2'd0, 3'b001, 32'h7700_0001, 4'hF, 1'b0);
    step();
    checkOutput("t6_err_after_beat2", 32'(bus.W_LAST_ERR), 32'(ERR_EXP));
    checkOutput("t6_free_mid", 32'(bus.AW_FREE), 32'd0);
    applyStimulus(0, 1'b1, 32'h7700_0002, 4'hF, 1'b1);
    pushBeat(2'd0, 3'b001, 32'h7700_0002, 4'hF, 1'b1);
    step();
    applyStimulus(0, 1'b0, 32'h0, 4'h0, 1'b0);
    #1;
    checkOutput("t6_free_after", 32'(bus.AW_FREE), 32'd1);
    checkOutput("t6_err_sticky", 32'(bus.W_LAST_ERR), 32'(ERR_EXP));
    step();
    checkOutput("t6_err_still", 32'(bus.W_LAST_ERR), 32'(ERR_EXP));
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("t6_err_cleared", 32'(bus.W_LAST_ERR), 32'd0);

    step();
    step();
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
